irq_counter_unit: RTL
=====================

Name: irq_counter_unit

Overview:
- Parametrised, multi-mode mapper IRQ generator for the multicart; successor to the per-mapper inline IRQ counters.
- One instance serves MMC3-style scanline counting (filtered PPU A12), FME-7-style CPU-cycle countdown and VRC-style prescaled scanline/cycle counting.
- Selected by the mapper decode logic through a small register-write port; drives the cartridge irq line.

Parameters:
- COUNT_WIDTH, 16, counter/latch width in bits; must be 8..16; MMC3 and VRC modes use bits [7:0] only.
- A12_FILTER, 3, consecutive m2 samples with A12 low required before a rising A12 counts.
- MMC3_REV_A, 0, 1 selects old-MMC3 behaviour: no IRQ when reload produces 0 without a pending reload request.
- PRESCALE_PERIOD, 341, VRC prescaler reload value (PPU dots per scanline).
- PRESCALE_STEP, 3, VRC prescaler decrement per m2 (PPU dots per CPU cycle).

Ports:
- m2  input  1  CPU clock; all state changes on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- mode  input  2  0=MMC3 scanline, 1=CPU cycle (FME-7), 2=VRC, 3=off.
- reg_we  input  1  one-m2-cycle register write strobe.
- reg_sel  input  3  register index.
- reg_data  input  8  write data.
- ppu_a12  input  1  PPU address bit 12, sampled on m2.
- irq_n  output  1  open-drain-style IRQ request, low = asserted.
- counter  output  COUNT_WIDTH  current counter value, for debug/readback.

Behaviour:
- Reset (async, rst_n=0): counter=0, latch=0, reload_req=0, enable=0, enable_after_ack=0, cycle_mode=0, prescaler=PRESCALE_PERIOD, filter count=0, irq_pending=0, irq_n=1.
- irq_n = ~irq_pending, registered; IRQ visible one m2 after the triggering event.
- Registers (reg_sel):
  - 0: latch[7:0]=data.
  - 1: latch[15:8]=data (ignored if COUNT_WIDTH=8).
  - 2: reload_req=1 (MMC3 $C001); in mode 1 copies latch to counter.
  - 3: enable=0, irq_pending=0 (MMC3 $E000 / disable).
  - 4: enable=1.
  - 5: VRC control: enable_after_ack=d0, enable=d1, cycle_mode=d2; if d1 then counter=latch[7:0], prescaler=PRESCALE_PERIOD; irq_pending=0.
  - 6: VRC ack: irq_pending=0, enable=enable_after_ack.
  - 7: reserved, no effect.
- A12 filter:
  - Counts m2 samples with A12 low, saturating at A12_FILTER.
  - A sampled rise with count>=A12_FILTER yields one a12_tick; count clears while A12 is high.
- Mode 0 (MMC3), on a12_tick:
  - If counter==0 or reload_req: counter=latch[7:0], reload_req=0; else counter-1.
  - If the resulting counter==0 and enable: irq_pending=1.
  - With MMC3_REV_A=1, the IRQ additionally requires old counter!=0 or reload_req.
- Mode 1 (cycle): every m2 while enable, counter decrements modulo 2^COUNT_WIDTH; on wrap 0 -> all-ones, irq_pending=1.
- Mode 2 (VRC), clock event while enable:
  - cycle_mode=1: clock every m2.
  - cycle_mode=0: prescaler-=PRESCALE_STEP; when the result is <=0, prescaler+=PRESCALE_PERIOD and clock.
  - On clock: if counter[7:0]==8'hFF then counter=latch[7:0], irq_pending=1; else counter+1.
- Mode 3: no counting; irq_pending held at 0.
- Any change of mode: irq_pending=0, prescaler=PRESCALE_PERIOD, filter count=0; counter and latch retained.
- Simultaneous events:
  - A register write to counter state (2, 5) overrides a same-cycle count.
  - A new IRQ event in the same cycle as an ack/disable leaves irq_pending=1.
- Counter arithmetic is width-exact; no carry out except the wrap detection.

Decomposition:
- Shared package irq_counter_pkg:
  - Mode constants IRQ_MODE_MMC3/CYCLE/VRC/OFF.
  - Register index constants IRQ_REG_LATCH_LO ... IRQ_REG_ACK.
  - Default PRESCALE_PERIOD/STEP.
- One sub-module a12_edge_filter: m2, rst_n, ppu_a12, A12_FILTER parameter, tick output.

Test Plan:
- Mode 0: latch=3, reload_req, enable, 5 filtered A12 rises (4 low samples each) -> counter 3,2,1,0 and irq_n low one m2 after the 4th rise; reg 3 -> irq_n high.
- Mode 0, A12 low for only 2 samples between rises (A12_FILTER=3) -> no a12_tick, counter unchanged.
- Mode 0, latch=0, MMC3_REV_A=0 vs 1, repeated rises -> IRQ on every rise vs only on the rise that follows a reload request.
- Mode 1: latch=16'h0002, reg 2, enable -> counter 1, 0, FFFF; irq_n low after the 3rd m2; reg 3 clears it.
- Mode 2: latch=8'hFE, reg 5 with data 0x02 -> prescaler path: first clock after 114 m2 (341/3 rounding), counter FF; next clock reloads FE and asserts irq; reg 6 with enable_after_ack=0 stops counting.
- Assert rst_n=0 mid-count with irq_n low -> irq_n=1, counter=0 immediately; also check that a write to reg 5 in the same m2 as a VRC clock leaves counter=latch.

Source files
------------

// File: rtl/irq_counter_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : irq_counter_pkg
//  Purpose  : Shared constants for the multi-mode mapper IRQ counter:
//             mode encodings, register indices and VRC prescaler defaults.
//  Revision : 1.0  initial release
// ============================================================================
package irq_counter_pkg;

    // Counting modes driven by the mapper decode logic
    localparam logic [1:0] IRQ_MODE_MMC3  = 2'd0;
    localparam logic [1:0] IRQ_MODE_CYCLE = 2'd1;
    localparam logic [1:0] IRQ_MODE_VRC   = 2'd2;
    localparam logic [1:0] IRQ_MODE_OFF   = 2'd3;

    // Register-write port indices
    localparam logic [2:0] IRQ_REG_LATCH_LO = 3'd0;
    localparam logic [2:0] IRQ_REG_LATCH_HI = 3'd1;
    localparam logic [2:0] IRQ_REG_RELOAD   = 3'd2;
    localparam logic [2:0] IRQ_REG_DISABLE  = 3'd3;
    localparam logic [2:0] IRQ_REG_ENABLE   = 3'd4;
    localparam logic [2:0] IRQ_REG_VRC_CTRL = 3'd5;
    localparam logic [2:0] IRQ_REG_ACK      = 3'd6;

    // VRC prescaler: PPU dots per scanline, PPU dots per CPU cycle
    localparam int IRQ_DEFAULT_PRESCALE_PERIOD = 341;
    localparam int IRQ_DEFAULT_PRESCALE_STEP   = 3;

endpackage
`default_nettype wire

// File: rtl/a12_edge_filter.sv
`default_nettype none
// ============================================================================
//  Module   : a12_edge_filter
//  Purpose  : Qualifies rising edges of PPU A12 sampled on m2. A rise only
//             produces a tick after A12 has been low for A12_FILTER
//             consecutive samples, rejecting the short A12 toggles seen
//             during sprite/background fetch interleaving.
//  Ports    : m2      - CPU clock, sampling edge
//             rst_n   - asynchronous active-low reset
//             clear   - synchronous clear of the low-sample count
//             ppu_a12 - PPU address bit 12
//             tick    - one-cycle qualified rise indication (combinational)
//  Revision : 1.0  initial release
// ============================================================================
module a12_edge_filter #(
    parameter int A12_FILTER = 3
) (
    input  logic m2,
    input  logic rst_n,
    input  logic clear,
    input  logic ppu_a12,
    output logic tick
);

    localparam int                 c_CNT_W  = $clog2(A12_FILTER + 2);
    localparam logic [c_CNT_W-1:0] c_FILTER = c_CNT_W'(A12_FILTER);

    logic [c_CNT_W-1:0] r_low_cnt;

    // A nonzero low count implies the previous sample was low, so a high
    // sample with a saturated count is by construction a qualified rise.
    assign tick = ppu_a12 && (r_low_cnt >= c_FILTER);

    always_ff @(posedge m2 or negedge rst_n) begin
        if (!rst_n) begin
            r_low_cnt <= '0;
        end else if (clear || ppu_a12) begin
            r_low_cnt <= '0;
        end else if (r_low_cnt < c_FILTER) begin
            r_low_cnt <= r_low_cnt + c_CNT_W'(1);
        end
    end

endmodule
`default_nettype wire

// File: rtl/irq_counter_unit.sv
`default_nettype none
// ============================================================================
//  Module   : irq_counter_unit
//  Purpose  : Multi-mode mapper IRQ generator: MMC3 filtered-A12 scanline
//             counter, FME-7 CPU-cycle countdown and VRC prescaled
//             scanline/cycle up-counter, programmed through a register port.
//  Ports    : m2       - CPU clock, all state changes on rising edge
//             rst_n    - asynchronous active-low reset
//             mode     - 0 MMC3, 1 CPU cycle, 2 VRC, 3 off
//             reg_we   - one-cycle register write strobe
//             reg_sel  - register index
//             reg_data - write data
//             ppu_a12  - PPU address bit 12
//             irq_n    - IRQ request, low = asserted
//             counter  - current counter value (readback)
//  Revision : 1.0  initial release
// ============================================================================
module irq_counter_unit
    import irq_counter_pkg::*;
#(
    parameter int COUNT_WIDTH     = 16,
    parameter int A12_FILTER      = 3,
    parameter int MMC3_REV_A      = 0,
    parameter int PRESCALE_PERIOD = IRQ_DEFAULT_PRESCALE_PERIOD,
    parameter int PRESCALE_STEP   = IRQ_DEFAULT_PRESCALE_STEP
) (
    input  logic                   m2,
    input  logic                   rst_n,
    input  logic [1:0]             mode,
    input  logic                   reg_we,
    input  logic [2:0]             reg_sel,
    input  logic [7:0]             reg_data,
    input  logic                   ppu_a12,
    output logic                   irq_n,
    output logic [COUNT_WIDTH-1:0] counter
);

    // Prescaler holds -STEP..PERIOD, so one extra bit serves as sign bit.
    localparam int                c_PS_W      = $clog2(PRESCALE_PERIOD + 1) + 1;
    localparam logic [c_PS_W-1:0] c_PS_PERIOD = c_PS_W'(PRESCALE_PERIOD);
    localparam logic [c_PS_W-1:0] c_PS_STEP   = c_PS_W'(PRESCALE_STEP);

    logic [COUNT_WIDTH-1:0] r_counter,    w_counter_nxt;
    logic [COUNT_WIDTH-1:0] r_latch,      w_latch_nxt;
    logic [c_PS_W-1:0]      r_prescaler,  w_prescaler_nxt;
    logic                   r_reload_req, w_reload_req_nxt;
    logic                   r_enable,     w_enable_nxt;
    logic                   r_en_after_ack, w_en_after_ack_nxt;
    logic                   r_cycle_mode, w_cycle_mode_nxt;
    logic                   r_irq_pending, w_irq_pending_nxt;
    logic [1:0]             r_mode_prev;

    logic        w_a12_tick;
    logic        w_mode_chg;
    logic [7:0]  w_cnt8;
    logic [7:0]  w_latch8;
    logic        w_mmc3_reload;
    logic [7:0]  w_mmc3_new;
    logic [c_PS_W-1:0] w_ps_dec;
    logic [15:0] w_latch16;
    logic        w_cnt_write;
    logic        w_clock;
    logic        w_irq_set;
    logic        w_irq_clr;

    assign w_mode_chg    = (mode != r_mode_prev);
    assign w_cnt8        = r_counter[7:0];
    assign w_latch8      = r_latch[7:0];
    assign w_mmc3_reload = (w_cnt8 == 8'd0) || r_reload_req;
    assign w_mmc3_new    = w_mmc3_reload ? w_latch8 : (w_cnt8 - 8'd1);
    assign w_ps_dec      = r_prescaler - c_PS_STEP;

    a12_edge_filter #(
        .A12_FILTER (A12_FILTER)
    ) u_a12_filter (
        .m2      (m2),
        .rst_n   (rst_n),
        .clear   (w_mode_chg),
        .ppu_a12 (ppu_a12),
        .tick    (w_a12_tick)
    );

    always_comb begin
        w_counter_nxt      = r_counter;
        w_prescaler_nxt    = r_prescaler;
        w_reload_req_nxt   = r_reload_req;
        w_enable_nxt       = r_enable;
        w_en_after_ack_nxt = r_en_after_ack;
        w_cycle_mode_nxt   = r_cycle_mode;
        w_latch16          = 16'(r_latch);
        w_cnt_write        = 1'b0;
        w_clock            = 1'b0;
        w_irq_set          = 1'b0;
        w_irq_clr          = 1'b0;

        // Register writes
        if (reg_we) begin
            case (reg_sel)
                IRQ_REG_LATCH_LO: w_latch16[7:0]  = reg_data;
                IRQ_REG_LATCH_HI: w_latch16[15:8] = reg_data;
                IRQ_REG_RELOAD: begin
                    w_reload_req_nxt = 1'b1;
                    w_cnt_write      = 1'b1;
                    if (mode == IRQ_MODE_CYCLE) begin
                        w_counter_nxt = r_latch;
                    end
                end
                IRQ_REG_DISABLE: begin
                    w_enable_nxt = 1'b0;
                    w_irq_clr    = 1'b1;
                end
                IRQ_REG_ENABLE: w_enable_nxt = 1'b1;
                IRQ_REG_VRC_CTRL: begin
                    w_en_after_ack_nxt = reg_data[0];
                    w_enable_nxt       = reg_data[1];
                    w_cycle_mode_nxt   = reg_data[2];
                    w_irq_clr          = 1'b1;
                    w_cnt_write        = 1'b1;
                    if (reg_data[1]) begin
                        w_counter_nxt   = COUNT_WIDTH'(w_latch8);
                        w_prescaler_nxt = c_PS_PERIOD;
                    end
                end
                IRQ_REG_ACK: begin
                    w_irq_clr    = 1'b1;
                    w_enable_nxt = r_en_after_ack;
                end
                default: ;
            endcase
        end
        // Latch high byte falls away when COUNT_WIDTH is 8
        w_latch_nxt = w_latch16[COUNT_WIDTH-1:0];

        // Counting; a counter-state write or a mode switch takes priority
        if (!w_cnt_write && !w_mode_chg) begin
            case (mode)
                IRQ_MODE_MMC3: begin
                    if (w_a12_tick) begin
                        w_counter_nxt = COUNT_WIDTH'(w_mmc3_new);
                        if (w_mmc3_reload) begin
                            w_reload_req_nxt = 1'b0;
                        end
                        // Old MMC3 stays silent when a zero latch reloads
                        // an already-zero counter without a reload request.
                        if ((w_mmc3_new == 8'd0) && r_enable &&
                            ((MMC3_REV_A == 0) || (w_cnt8 != 8'd0) || r_reload_req)) begin
                            w_irq_set = 1'b1;
                        end
                    end
                end
                IRQ_MODE_CYCLE: begin
                    if (r_enable) begin
                        w_counter_nxt = r_counter - COUNT_WIDTH'(1);
                        if (r_counter == '0) begin
                            w_irq_set = 1'b1;
                        end
                    end
                end
                IRQ_MODE_VRC: begin
                    if (r_enable) begin
                        if (r_cycle_mode) begin
                            w_clock = 1'b1;
                        end else if (w_ps_dec[c_PS_W-1] || (w_ps_dec == '0)) begin
                            w_prescaler_nxt = w_ps_dec + c_PS_PERIOD;
                            w_clock         = 1'b1;
                        end else begin
                            w_prescaler_nxt = w_ps_dec;
                        end
                        if (w_clock) begin
                            if (w_cnt8 == 8'hFF) begin
                                w_counter_nxt = COUNT_WIDTH'(w_latch8);
                                w_irq_set     = 1'b1;
                            end else begin
                                w_counter_nxt = COUNT_WIDTH'(w_cnt8 + 8'd1);
                            end
                        end
                    end
                end
                default: ;
            endcase
        end

        if (w_mode_chg) begin
            w_prescaler_nxt = c_PS_PERIOD;
        end

        // A fresh IRQ event wins over a same-cycle ack/disable
        if (w_mode_chg || (mode == IRQ_MODE_OFF)) begin
            w_irq_pending_nxt = 1'b0;
        end else if (w_irq_set) begin
            w_irq_pending_nxt = 1'b1;
        end else if (w_irq_clr) begin
            w_irq_pending_nxt = 1'b0;
        end else begin
            w_irq_pending_nxt = r_irq_pending;
        end
    end

    always_ff @(posedge m2 or negedge rst_n) begin
        if (!rst_n) begin
            r_counter      <= '0;
            r_latch        <= '0;
            r_prescaler    <= c_PS_PERIOD;
            r_reload_req   <= 1'b0;
            r_enable       <= 1'b0;
            r_en_after_ack <= 1'b0;
            r_cycle_mode   <= 1'b0;
            r_irq_pending  <= 1'b0;
            r_mode_prev    <= IRQ_MODE_MMC3;
        end else begin
            r_counter      <= w_counter_nxt;
            r_latch        <= w_latch_nxt;
            r_prescaler    <= w_prescaler_nxt;
            r_reload_req   <= w_reload_req_nxt;
            r_enable       <= w_enable_nxt;
            r_en_after_ack <= w_en_after_ack_nxt;
            r_cycle_mode   <= w_cycle_mode_nxt;
            r_irq_pending  <= w_irq_pending_nxt;
            r_mode_prev    <= mode;
        end
    end

    assign irq_n   = ~r_irq_pending;
    assign counter = r_counter;

endmodule
`default_nettype wire
